// File: rtl/vedic_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Optional build macro: DIV_SELFCHECK_EN (adds the chk_err self-check output).
package vedic_div_pkg;

  // Default dividend/quotient width (also the number of iterations).
  localparam int DW_DEF = 8;
  // Default divisor/remainder width.
  localparam int VW_DEF = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The iteration counter must reach DW itself, so it needs $clog2(DW+1) bits.
  function automatic int cntWidth(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CW_DEF = cntWidth(DW_DEF);

  // Quotient reported for a zero divisor at the default width.
  localparam logic [DW_DEF-1:0] Q_DBZ = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// then subtract the divisor when it fits.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] rem_i,
  input  logic          dvdBit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW-1:0] rem_o,
  output logic          qBit_o
);

  logic [VW:0] shifted;
  logic [VW:0] divExt;

  // The incoming remainder is always below the divisor, so VW+1 bits hold the shifted value.
  assign shifted = {rem_i, dvdBit_i};
  assign divExt  = {1'b0, divisor_i};

  // Compare and conditionally subtract; the result always fits back into VW bits.
  always_comb begin
    qBit_o = 1'b0;
    rem_o  = shifted[VW-1:0];
    if (shifted >= divExt) begin
      qBit_o = 1'b1;
      rem_o  = VW'(shifted - divExt);
    end
  end

endmodule

// File: rtl/vedic_seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Optional build macro: DIV_SELFCHECK_EN adds chk_err, a sticky flag raised
// when quotient*divisor+remainder disagrees with the captured dividend.
module vedic_seq_divider
  import vedic_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
`ifdef DIV_SELFCHECK_EN
  output logic          dbz,
  output logic          chk_err
`else
  output logic          dbz
`endif
);

  localparam int CW = cntWidth(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW-1:0] rem_q;
  logic [DW-1:0] qacc_q;
  logic          zdiv_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] remo_q;
  logic          dbz_q;

  logic [VW-1:0] rem_d;
  logic          qBit_d;
  logic          accept;

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;

  div_step #(
    .VW(VW)
  ) u_step (
    .rem_i    (rem_q),
    .dvdBit_i (dvd_q[DW-1]),
    .divisor_i(dvs_q),
    .rem_o    (rem_d),
    .qBit_o   (qBit_d)
  );

  // Controller, datapath and registered outputs. A zero divisor enters RUN with
  // the counter already at its final value, so it finishes one edge after start
  // without ever raising busy. Results are published only on the finishing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qacc_q  <= '0;
      zdiv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            rem_q   <= '0;
            qacc_q  <= '0;
            busy_q  <= 1'b0;
            if (divisor == '0) begin
              zdiv_q <= 1'b1;
              cnt_q  <= CNT_LAST;
            end else begin
              zdiv_q <= 1'b0;
              cnt_q  <= '0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (zdiv_q) begin
              quot_q <= '1;
              remo_q <= '0;
              dbz_q  <= 1'b1;
            end else begin
              quot_q <= qacc_q;
              remo_q <= rem_q;
              dbz_q  <= 1'b0;
            end
          end else begin
            rem_q  <= rem_d;
            dvd_q  <= {dvd_q[DW-2:0], 1'b0};
            qacc_q <= {qacc_q[DW-2:0], qBit_d};
            cnt_q  <= cnt_q + CW'(1);
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign dbz       = dbz_q;

`ifdef DIV_SELFCHECK_EN
  localparam int PW = DW + VW;

  logic [DW-1:0] orig_q;
  logic          chkErr_q;
  logic [PW-1:0] chkSum;

  assign chkSum = PW'(quot_q) * PW'(dvs_q) + PW'(remo_q);

  // Keep the untouched dividend, since the working copy is shifted away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orig_q <= '0;
    end else if (accept) begin
      orig_q <= dividend;
    end
  end

  // Reconstruct the dividend during the done cycle; any disagreement latches until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chkErr_q <= 1'b0;
    end else if ((state_q == DONE) && !dbz_q && (chkSum != PW'(orig_q))) begin
      chkErr_q <= 1'b1;
    end
  end

  assign chk_err = chkErr_q;
`else
  logic unusedAccept;
  assign unusedAccept = accept;
`endif

endmodule

// File: tb/tb_vedic_seq_divider.sv
// Scoreboard bench for vedic_seq_divider: stimulus pushes expected results,
// a monitor pops and compares them on every done pulse.
module tb_vedic_seq_divider;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dbz;
`ifdef DIV_SELFCHECK_EN
  logic       chkErr;
`endif

  exp_t expQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  vedic_seq_divider dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
`ifdef DIV_SELFCHECK_EN
    .dbz      (dbz),
    .chk_err  (chkErr)
`else
    .dbz      (dbz)
`endif
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int expv);
    vecCount++;
    if (act != expv) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("dbz", dbz, e.dbz);
      end
    end
  end

  // Issue one division, optionally toggling start/operands during RUN, and measure timing.
  task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b,
                               input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                               input int expLat, input int expBusy,
                               input bit toggle, input bit chkTiming);
    exp_t e;
    int lat;
    int busyCnt;
    bit got;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = eq;
    e.r = er;
    e.dbz = edbz;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    busyCnt = 0;
    got = 1'b0;
    while (lat < 30 && !got) begin
      @(posedge clk);
      lat++;
      if (toggle && lat < 6) begin
        #1;
        start    = ~start;
        dividend = 8'd5;
        divisor  = 4'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      checkOutput("doneTimeout", 0, 1);
    end else if (chkTiming) begin
      checkOutput("latency", lat, expLat);
      checkOutput("busyCycles", busyCnt, expBusy);
    end
  endtask

  initial begin
    int waitCnt;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstQuot", quotient, 0);
    checkOutput("rstRem", remainder, 0);
    checkOutput("rstDbz", dbz, 0);
    rst = 1'b0;

    // 225/15: latency 9 edges, busy 8 cycles.
    applyStimulus(8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 9, 8, 1'b0, 1'b1);

    // Back-to-back: 200/7 then 20/4 issued in the done cycle.
    applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9, 8, 1'b0, 1'b1);
    dividend = 8'd20;
    divisor  = 4'd4;
    start    = 1'b1;
    begin
      exp_t e2;
      e2.q = 8'd5;
      e2.r = 4'd0;
      e2.dbz = 1'b0;
      expQ.push_back(e2);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("doneFall", done, 0);
    repeat (3) @(negedge clk);
    checkOutput("holdQuot", quotient, 28);
    checkOutput("holdRem", remainder, 4);
    waitCnt = 0;
    while (!done && waitCnt < 30) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("b2bDoneSeen", done, 1);

    // Divide by zero fast path, then a valid division clears dbz.
    applyStimulus(8'd9, 4'd0, 8'd255, 4'd0, 1'b1, 1, 0, 1'b0, 1'b1);
    applyStimulus(8'd6, 4'd3, 8'd2, 4'd0, 1'b0, 9, 8, 1'b0, 1'b1);

    // Start toggling during RUN must be ignored.
    applyStimulus(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9, 8, 1'b1, 1'b1);

    // Reset in the middle of 100/3: immediate clear, no done.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortQuot", quotient, 0);
    checkOutput("abortRem", remainder, 0);
    checkOutput("abortDone", done, 0);
    repeat (10) @(negedge clk);
    checkOutput("abortNoDone", done, 0);
    rst = 1'b0;
    applyStimulus(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9, 8, 1'b0, 1'b1);

    // Sweep all dividends against every nonzero divisor.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        applyStimulus(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 9, 8, 1'b0, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboardDrain", expQ.size(), 0);
`ifdef DIV_SELFCHECK_EN
    checkOutput("chkErr", chkErr, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
